hazard_scoreboard_unit: RTL and testbench
=========================================

# hazard_scoreboard_unit

Parametrised successor to the five-stage pipeline hazard detector. Sits beside the IF/ID/EX/MEM/WB pipeline registers and drives their stall/bubble controls. Adds a register scoreboard for out-of-line long-latency (mul/div) writebacks, taken-only control flush, and a miss-duration watchdog FSM. Optional saturating performance counters.

## Interface
- REG_AW, 5, register address width; register 0 never hazards
- MISS_TIMEOUT, 255, consecutive miss cycles before `miss_timeout` sets (>=1)
- PERF_W, 32, perf counter width

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- branch_id, jal_id, jalr_id, pc_src_id  in  1 each  control instr in ID; pc_src_id = redirect taken
- rs1_id, rs2_id, rd_id  in  REG_AW  ID register fields
- rs1_used_id, rs2_used_id, reg_write_id  in  1 each  field valid flags
- rd_ex, rd_mem  in  REG_AW  destinations in EX/MEM
- reg_write_ex, mem_read_ex, mem_read_mem  in  1 each
- md_issue_ex  in  1  EX instr is long-latency; result returns via md_done
- md_done  in  1  long-latency writeback this cycle
- md_done_rd  in  REG_AW  its destination
- miss  in  1  cache miss, freeze request
- stall_if/id/ex/mem/wb, bubble_if/id/ex/mem/wb  out  1 each
- miss_timeout  out  1  sticky watchdog flag
- perf_stall_cnt, perf_flush_cnt  out  PERF_W  see Configuration

## Operation
- Match(a,b) = (a==b) && (a!=0); src match requires the corresponding *_used_id.
- load_use = mem_read_ex && src match rd_ex.
- ctrl_haz = (branch_id|jalr_id) && ((reg_write_ex && src match rd_ex) || (mem_read_mem && src match rd_mem)); jalr checks rs1 only.
- sb_haz = busy[rs1]/busy[rs2] on used sources (RAW), or reg_write_id && busy[rd_id] (WAW).
- data_stall = load_use | ctrl_haz | sb_haz.
- Priority: miss > data_stall > flush.
  - miss: all stall_* =1, all bubble_* =0.
  - data_stall: stall_if=stall_id=1, bubble_ex=1, rest 0.
  - else flush = pc_src_id|jal_id|jalr_id: bubble_id=1; not-taken branch no flush.
- bubble_if, bubble_mem, bubble_wb are always 0.
- Scoreboard busy[2^REG_AW]: set rd_ex when md_issue_ex && !miss && !data_stall... (EX not stalled: !miss) && rd_ex!=0; clear md_done_rd when md_done. Same reg set+clear same cycle: set wins. md_done during miss still clears.
- FSM states RUN, MISS, ERR:
  - RUN→MISS on miss (cnt←1); MISS→RUN on !miss (cnt←0); MISS stays, cnt+1.
  - MISS→ERR when cnt==MISS_TIMEOUT; ERR held until reset; miss_timeout=1 in ERR only.
  - In ERR stall/bubble logic unchanged (still follows miss).

## Timing
- stall_*/bubble_* combinational from inputs + registered busy; no latency.
- Scoreboard update visible to sb_haz next cycle; md_done in cycle N unblocks ID in N+1.
- miss_timeout rises the cycle after the MISS_TIMEOUT-th consecutive miss cycle.
- Reset (rst low, async): busy all 0, state RUN, cnt 0, miss_timeout 0, perf counters 0; all stall_*/bubble_* forced 0 while rst low.
- Reset mid-miss or with busy bits: all cleared immediately; no pending writeback survives.

## Configuration
- HAZARD_PERF_CNT_EN defined: perf_stall_cnt +1 each cycle stall_id=1; perf_flush_cnt +1 each cycle bubble_id=1; both saturate at all-ones.
- Undefined: counter registers absent, ports kept and tied to 0.

## Structure
- Package hazard_pkg: FSM state enum (RUN/MISS/ERR), REG_ZERO constant, priority-cause enum used by the bench.
- Sub-module reg_scoreboard: busy vector, set/clear ports, two read ports + WAW port.

## Test plan
- mem_read_ex=1, rd_ex=5, rs1_id=5 used → stall_if=stall_id=bubble_ex=1; rs1_id=0 with rd_ex=0 → no stall.
- md_issue_ex rd_ex=7, next cycle rs2_id=7 → stall until md_done rd=7; ID released cycle after; simultaneous issue+done on 7 → busy stays 1.
- branch_id, pc_src_id=0, no hazards → bubble_id=0; pc_src_id=1 → bubble_id=1; with load_use too → bubble_id=0, bubble_ex=1.
- miss held with load_use → all stall=1, all bubble=0; MISS_TIMEOUT=4, miss 4 cycles → miss_timeout=1 next cycle, sticky after miss drops; 3 cycles → stays 0.
- Assert rst mid-miss with busy[3]=1 → outputs 0 at once; after release rs1_id=3 no stall.
- With HAZARD_PERF_CNT_EN, PERF_W=4: 20 stall cycles → perf_stall_cnt=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard unit: watchdog FSM states, the
// architectural zero register and the stall/flush priority cause.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        ERR  = 2'd2
    } wd_state_e;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_FLUSH = 2'd1,
        CAUSE_DATA  = 2'd2,
        CAUSE_MISS  = 2'd3
    } cause_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register for long-latency results still in flight.
// Two source read ports plus one destination (WAW) read port; a set beats a clear.
module reg_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_rd,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_rd,
    input  logic [REG_AW-1:0] i_rd_a_addr,
    input  logic [REG_AW-1:0] i_rd_b_addr,
    input  logic [REG_AW-1:0] i_waw_addr,
    output logic              o_rd_a_busy,
    output logic              o_rd_b_busy,
    output logic              o_waw_busy
);

    localparam int NREG = 1 << REG_AW;
    localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;

    // Register 0 can never become busy, so readers need no zero check.
    assign w_set_mask = i_set_en ? ((ONE_HOT0 << i_set_rd) & ~ONE_HOT0) : '0;
    assign w_clr_mask = i_clr_en ? (ONE_HOT0 << i_clr_rd) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_rd_a_busy = r_busy[i_rd_a_addr];
    assign o_rd_b_busy = r_busy[i_rd_b_addr];
    assign o_waw_busy  = r_busy[i_waw_addr];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline stall/bubble control with long-latency scoreboard and miss watchdog.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush perf counters.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int MISS_TIMEOUT = 255,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_id,
    input  logic              jal_id,
    input  logic              jalr_id,
    input  logic              pc_src_id,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic              reg_write_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic              mem_read_mem,
    input  logic              md_issue_ex,
    input  logic              md_done,
    input  logic [REG_AW-1:0] md_done_rd,
    input  logic              miss,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              stall_wb,
    output logic              bubble_if,
    output logic              bubble_id,
    output logic              bubble_ex,
    output logic              bubble_mem,
    output logic              bubble_wb,
    output logic              miss_timeout,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    localparam int CNT_W = (MISS_TIMEOUT < 1) ? 1 : $clog2(MISS_TIMEOUT + 1);

    function automatic logic f_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && (a != REG_AW'(REG_ZERO));
    endfunction

    logic w_s1_ex, w_s2_ex, w_s1_mem, w_s2_mem;
    logic w_load_use, w_ctrl_haz, w_sb_haz, w_data_stall, w_flush;
    logic w_busy_a, w_busy_b, w_busy_waw;

    wd_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

    assign w_s1_ex  = rs1_used_id && f_match(rs1_id, rd_ex);
    assign w_s2_ex  = rs2_used_id && f_match(rs2_id, rd_ex);
    assign w_s1_mem = rs1_used_id && f_match(rs1_id, rd_mem);
    assign w_s2_mem = rs2_used_id && f_match(rs2_id, rd_mem);

    assign w_load_use = mem_read_ex && (w_s1_ex || w_s2_ex);

    // Branches compare in ID so need both sources resolved; jalr only reads rs1.
    assign w_ctrl_haz =
        (branch_id && ((reg_write_ex && (w_s1_ex || w_s2_ex)) ||
                       (mem_read_mem && (w_s1_mem || w_s2_mem)))) ||
        (jalr_id && ((reg_write_ex && w_s1_ex) || (mem_read_mem && w_s1_mem)));

    assign w_sb_haz = (rs1_used_id && w_busy_a) || (rs2_used_id && w_busy_b) ||
                      (reg_write_id && w_busy_waw);

    assign w_data_stall = w_load_use || w_ctrl_haz || w_sb_haz;
    assign w_flush      = pc_src_id || jal_id || jalr_id;

    // A data stall only holds IF/ID; the long-latency op in EX still issues.
    reg_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_set_en    (md_issue_ex && !miss),
        .i_set_rd    (rd_ex),
        .i_clr_en    (md_done),
        .i_clr_rd    (md_done_rd),
        .i_rd_a_addr (rs1_id),
        .i_rd_b_addr (rs2_id),
        .i_waw_addr  (rd_id),
        .o_rd_a_busy (w_busy_a),
        .o_rd_b_busy (w_busy_b),
        .o_waw_busy  (w_busy_waw)
    );

    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        stall_mem  = 1'b0;
        stall_wb   = 1'b0;
        bubble_if  = 1'b0;
        bubble_id  = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        bubble_wb  = 1'b0;
        if (!rst) begin
            stall_if = 1'b0;
        end else if (miss) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            stall_wb  = 1'b1;
        end else if (w_data_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (w_flush) begin
            bubble_id = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // w_cnt_inc is the length of the miss run including the current cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = (r_state == RUN) ? CNT_W'(1) : r_cnt + CNT_W'(1);
        case (r_state)
            RUN, MISS: begin
                if (miss) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = (w_cnt_inc == CNT_W'(MISS_TIMEOUT)) ? ERR : MISS;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        miss_timeout = (r_state == ERR);
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (stall_id && !(&r_perf_stall)) begin
                r_perf_stall <= r_perf_stall + PERF_W'(1);
            end
            if (bubble_id && !(&r_perf_flush)) begin
                r_perf_flush <= r_perf_flush + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit; expectations queued by the
// stimulus and popped/compared by an independent negedge monitor.
module tb_hazard_scoreboard_unit;
    import hazard_pkg::*;

    localparam int AW = 5;
    localparam int PW = 4;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic          rst;
    logic          branch_id, jal_id, jalr_id, pc_src_id;
    logic [AW-1:0] rs1_id, rs2_id, rd_id, rd_ex, rd_mem, md_done_rd;
    logic          rs1_used_id, rs2_used_id, reg_write_id;
    logic          reg_write_ex, mem_read_ex, mem_read_mem;
    logic          md_issue_ex, md_done, miss;
    logic          stall_if, stall_id, stall_ex, stall_mem, stall_wb;
    logic          bubble_if, bubble_id, bubble_ex, bubble_mem, bubble_wb;
    logic          miss_timeout;
    logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;

    hazard_scoreboard_unit #(.REG_AW(AW), .MISS_TIMEOUT(4), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .branch_id(branch_id), .jal_id(jal_id), .jalr_id(jalr_id), .pc_src_id(pc_src_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .reg_write_id(reg_write_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_read_mem(mem_read_mem),
        .md_issue_ex(md_issue_ex), .md_done(md_done), .md_done_rd(md_done_rd), .miss(miss),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .stall_mem(stall_mem), .stall_wb(stall_wb),
        .bubble_if(bubble_if), .bubble_id(bubble_id), .bubble_ex(bubble_ex),
        .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
        .miss_timeout(miss_timeout),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PW-1:0] EXP_STALL20 = 4'd15;
    localparam logic [PW-1:0] EXP_FLUSH3  = 4'd3;
`else
    localparam logic [PW-1:0] EXP_STALL20 = 4'd0;
    localparam logic [PW-1:0] EXP_FLUSH3  = 4'd0;
`endif

    typedef struct {
        string         name;
        cause_e        cause;
        logic          to;
        logic          chk_perf;
        logic [PW-1:0] ps;
        logic [PW-1:0] pf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // {stall if..wb, bubble if..wb}
    function automatic logic [9:0] ctl_of(input cause_e c);
        case (c)
            CAUSE_MISS:  return 10'b11111_00000;
            CAUSE_DATA:  return 10'b11000_00100;
            CAUSE_FLUSH: return 10'b00000_01000;
            default:     return 10'b00000_00000;
        endcase
    endfunction

    exp_t       m_e;
    logic [9:0] m_got;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e   = q.pop_front();
            m_got = {stall_if, stall_id, stall_ex, stall_mem, stall_wb,
                     bubble_if, bubble_id, bubble_ex, bubble_mem, bubble_wb};
            checks++;
            if (m_got !== ctl_of(m_e.cause) || miss_timeout !== m_e.to) begin
                errors++;
                $display("FAIL %s: got ctl=%b to=%b, want ctl=%b to=%b",
                         m_e.name, m_got, miss_timeout, ctl_of(m_e.cause), m_e.to);
            end
            if (m_e.chk_perf) begin
                checks++;
                if (perf_stall_cnt !== m_e.ps || perf_flush_cnt !== m_e.pf) begin
                    errors++;
                    $display("FAIL %s_perf: got stall_cnt=%0d flush_cnt=%0d, want %0d %0d",
                             m_e.name, perf_stall_cnt, perf_flush_cnt, m_e.ps, m_e.pf);
                end
            end
        end
    end

    task automatic clr();
        branch_id = 0; jal_id = 0; jalr_id = 0; pc_src_id = 0;
        rs1_id = 0; rs2_id = 0; rd_id = 0; rd_ex = 0; rd_mem = 0; md_done_rd = 0;
        rs1_used_id = 0; rs2_used_id = 0; reg_write_id = 0;
        reg_write_ex = 0; mem_read_ex = 0; mem_read_mem = 0;
        md_issue_ex = 0; md_done = 0; miss = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic push(input string n, input cause_e c, input logic to);
        exp_t e;
        e.name = n; e.cause = c; e.to = to; e.chk_perf = 1'b0; e.ps = '0; e.pf = '0;
        q.push_back(e);
    endtask

    task automatic push_perf(input string n, input cause_e c, input logic to,
                             input logic [PW-1:0] ps, input logic [PW-1:0] pf);
        exp_t e;
        e.name = n; e.cause = c; e.to = to; e.chk_perf = 1'b1; e.ps = ps; e.pf = pf;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b0;
        clr();
        @(posedge clk);
        #1;
        miss = 1; mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1; jal_id = 1;
        push_perf("reset_forced", CAUSE_NONE, 1'b0, 4'd0, 4'd0);

        nxt(); rst = 1;
        mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1;
        push("load_use_rs1", CAUSE_DATA, 1'b0);
        nxt(); mem_read_ex = 1; rd_ex = 0; rs1_id = 0; rs1_used_id = 1;
        push("load_use_x0", CAUSE_NONE, 1'b0);
        nxt(); mem_read_ex = 1; rd_ex = 6; rs2_id = 6; rs2_used_id = 0;
        push("load_use_unused", CAUSE_NONE, 1'b0);

        nxt(); md_issue_ex = 1; rd_ex = 7;
        push("md_issue7", CAUSE_NONE, 1'b0);
        nxt(); rs2_id = 7; rs2_used_id = 1;
        push("sb_raw7", CAUSE_DATA, 1'b0);
        nxt(); rs2_id = 7; rs2_used_id = 1; md_done = 1; md_done_rd = 7;
        push("sb_done_cycle", CAUSE_DATA, 1'b0);
        nxt(); rs2_id = 7; rs2_used_id = 1;
        push("sb_released", CAUSE_NONE, 1'b0);

        nxt(); md_issue_ex = 1; rd_ex = 9;
        push("md_issue9", CAUSE_NONE, 1'b0);
        nxt(); reg_write_id = 1; rd_id = 9; md_issue_ex = 1; rd_ex = 9; md_done = 1; md_done_rd = 9;
        push("waw_set_clr", CAUSE_DATA, 1'b0);
        nxt(); reg_write_id = 1; rd_id = 9;
        push("set_wins", CAUSE_DATA, 1'b0);
        nxt(); reg_write_id = 1; rd_id = 9; md_done = 1; md_done_rd = 9;
        push("waw_done", CAUSE_DATA, 1'b0);
        nxt(); reg_write_id = 1; rd_id = 9;
        push("waw_clear", CAUSE_NONE, 1'b0);

        nxt(); branch_id = 1;
        push("br_not_taken", CAUSE_NONE, 1'b0);
        nxt(); branch_id = 1; pc_src_id = 1;
        push("br_taken", CAUSE_FLUSH, 1'b0);
        nxt(); branch_id = 1; pc_src_id = 1; mem_read_ex = 1; rd_ex = 4; rs1_id = 4; rs1_used_id = 1;
        push("br_taken_lu", CAUSE_DATA, 1'b0);
        nxt(); jal_id = 1;
        push("jal_flush", CAUSE_FLUSH, 1'b0);
        nxt(); branch_id = 1; reg_write_ex = 1; rd_ex = 6; rs2_id = 6; rs2_used_id = 1;
        push("ctrl_ex_rs2", CAUSE_DATA, 1'b0);
        nxt(); jalr_id = 1; reg_write_ex = 1; rd_ex = 6; rs2_id = 6; rs2_used_id = 1; rs1_used_id = 1;
        push("jalr_rs2_ign", CAUSE_FLUSH, 1'b0);
        nxt(); branch_id = 1; mem_read_mem = 1; rd_mem = 8; rs1_id = 8; rs1_used_id = 1;
        push("ctrl_mem_rs1", CAUSE_DATA, 1'b0);

        nxt(); miss = 1; mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1;
        push("miss_lu", CAUSE_MISS, 1'b0);
        nxt(); miss = 1; md_issue_ex = 1; rd_ex = 12;
        push("miss_issue", CAUSE_MISS, 1'b0);
        nxt(); rs1_id = 12; rs1_used_id = 1;
        push("miss_no_set", CAUSE_NONE, 1'b0);

        for (int i = 0; i < 3; i++) begin
            nxt(); miss = 1;
            push("miss3", CAUSE_MISS, 1'b0);
        end
        nxt(); push("miss3_end", CAUSE_NONE, 1'b0);

        for (int i = 0; i < 4; i++) begin
            nxt(); miss = 1;
            push("miss4", CAUSE_MISS, 1'b0);
        end
        nxt(); push("timeout_set", CAUSE_NONE, 1'b1);
        nxt(); push("timeout_sticky", CAUSE_NONE, 1'b1);
        nxt(); miss = 1;
        push("err_miss", CAUSE_MISS, 1'b1);

        nxt(); md_issue_ex = 1; rd_ex = 3;
        push("issue3", CAUSE_NONE, 1'b1);
        nxt(); miss = 1; rst = 0;
        push_perf("rst_mid_miss", CAUSE_NONE, 1'b0, 4'd0, 4'd0);
        nxt(); rst = 1; rs1_id = 3; rs1_used_id = 1;
        push("busy3_cleared", CAUSE_NONE, 1'b0);

        for (int i = 0; i < 20; i++) begin
            nxt(); mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1;
            push("perf_stall", CAUSE_DATA, 1'b0);
        end
        nxt(); push_perf("perf_sat", CAUSE_NONE, 1'b0, EXP_STALL20, 4'd0);
        for (int i = 0; i < 3; i++) begin
            nxt(); jal_id = 1;
            push("perf_flush", CAUSE_FLUSH, 1'b0);
        end
        nxt(); push_perf("perf_flush_cnt", CAUSE_NONE, 1'b0, EXP_STALL20, EXP_FLUSH3);

        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
